minhash_bottomk_sorter: RTL and testbench
=========================================

# minhash_bottomk_sorter

Clocked, parametrised bottom-k sketch builder for the MinHash pipeline. It accepts a stream of (signature, index) pairs for one sequence and keeps the NUM_SLOTS smallest signatures, sorted ascending. On the last beat it drains the retained indices in sorted order over a valid/ready stream, then clears itself for the next sequence. It sits between the k-mer hash stage and the sketch writer.

## Interface
- SIGNATURE_WIDTH, 32: width of k-mer signature
- INDEX_WIDTH, 10: width of k-mer index
- NUM_SLOTS, 8: retained signatures (k), ≥2
- SLOT_W, $clog2(NUM_SLOTS+1): width of fill count
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat; handshake = in_valid & in_ready
- in_signature  in  SIGNATURE_WIDTH  k-mer signature
- in_index  in  INDEX_WIDTH  k-mer index
- in_last  in  1  final beat of the sequence
- out_valid  out  1  drained entry valid
- out_ready  in  1  downstream accepts; handshake = out_valid & out_ready
- out_signature  out  SIGNATURE_WIDTH  retained signature, ascending order
- out_index  out  INDEX_WIDTH  matching index
- out_last  out  1  final drained entry
- fill_count  out  SLOT_W  number of occupied slots

## Operation
- Storage: NUM_SLOTS slots, each {valid, signature, index}; slot 0 holds the smallest value. Occupied slots always form a contiguous prefix.
- States: ACCEPT (reset state) and DRAIN.
- ACCEPT: in_ready=1, out_valid=0. Per accepted beat, lt[i] = !valid[i] | (in_signature < sig[i]). The insertion point p is the lowest i with lt[i]. Slots below p are held, slot p takes the input, and slots above p take slot i-1, so the last slot is evicted when full. If no lt[i] is set, the beat is dropped.
- Ties: comparison is strict, so an equal signature inserts after the existing equals and the earlier index keeps priority.
- fill_count increments on insertion and saturates at NUM_SLOTS.
- An accepted beat with in_last=1 is inserted as normal, then the block moves to DRAIN with rd_ptr=0.
- DRAIN: in_ready=0, out_valid=1. out_signature/out_index come from slot[rd_ptr], and out_last=(rd_ptr==fill_count-1). On each out handshake rd_ptr increments. On the out_last handshake, all valid bits are cleared, fill_count=0, and the block returns to ACCEPT.
- DRAIN with fill_count==0 is unreachable. The defined behaviour if it occurs is: clear the slots and return to ACCEPT without asserting out_valid.
- out_ready low holds all outputs stable.
- Unsigned compare throughout; the all-ones signature is a legal value and is distinct from an empty slot.

## Timing
- Reset: state=ACCEPT, all valid=0, every signature/index=0, fill_count=0, rd_ptr=0, in_ready=1, out_valid=0, out_signature=0, out_index=0, out_last=0.
- Insertion is single cycle: a beat accepted at edge n is visible in the slots and fill_count after edge n.
- Throughput is 1 beat/cycle in ACCEPT.
- out_valid rises the cycle after the in_last handshake.
- Drain takes fill_count cycles at out_ready=1. in_ready returns to 1 the cycle after the out_last handshake. No overlap between sequences.
- rst mid-sequence or mid-drain aborts immediately and discards all contents; rst has priority over every handshake in the same cycle.

## Configuration
- SORTER_DEDUP_EN defined: an accepted beat whose signature equals any valid stored signature is discarded. Slots and fill_count are unchanged; the beat still counts as in_last if flagged. This gives set semantics.
- SORTER_DEDUP_EN undefined: duplicates are inserted per the tie rule above.

## Structure
- minhash_pkg holds:
  - the state enum (ACCEPT, DRAIN)
  - the slot struct {valid, signature, index}
  - the default width constants shared with the hash stage
- One sub-module, bottomk_insert_cell, is instantiated NUM_SLOTS times. Inputs: own slot, left-neighbour slot, left-neighbour lt, incoming beat. Outputs: own lt and next slot value.

## Test plan
- NUM_SLOTS=4. Signatures 50,40,30,20,10 (idx 0..4), last on idx 4 → drain 10,20,30,40 with idx 4,3,2,1; out_last on the 4th entry; in_ready=1 the cycle after it.
- Two beats only, 7 then 3 with last → fill_count=2; drain 3,7; out_last on the 2nd entry.
- Fill with 1,2,3,4, then send 9 with last → 9 is dropped; drain 1,2,3,4.
- Duplicates 5(idx0),5(idx1),6 with last → with SORTER_DEDUP_EN: drain 5/idx0, 6. Without it: drain 5/idx0, 5/idx1, 6.
- Hold out_ready=0 for 5 cycles during drain → outputs stable, no entry lost; in_valid asserted meanwhile is not accepted.
- Assert rst mid-drain after 2 entries → next cycle out_valid=0, fill_count=0, in_ready=1; the next sequence drains only its own data.

Source files
------------

// File: rtl/minhash_pkg.sv
// Shared MinHash pipeline types: sorter state, slot record and default
// widths used by the hash stage, bottom-k sorter and sketch writer.
package minhash_pkg;

    localparam int SIG_W_DEF = 32;
    localparam int IDX_W_DEF = 10;
    localparam int SLOTS_DEF = 8;

    typedef enum logic {
        ACCEPT = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [SIG_W_DEF-1:0] signature;
        logic [IDX_W_DEF-1:0] index;
    } slot_t;

endpackage

// File: rtl/bottomk_insert_cell.sv
// One slot of the bottom-k insertion array.
// Ports: own/left slot, left_lt, incoming signature/index -> lt, nxt.
module bottomk_insert_cell
    import minhash_pkg::*;
#(
    parameter int  SIGNATURE_WIDTH = SIG_W_DEF,
    parameter int  INDEX_WIDTH     = IDX_W_DEF,
    parameter type cell_slot_t     = slot_t
) (
    input  cell_slot_t                 own,
    input  cell_slot_t                 left,
    input  logic                       left_lt,
    input  logic [SIGNATURE_WIDTH-1:0] in_signature,
    input  logic [INDEX_WIDTH-1:0]     in_index,
    output logic                       lt,
    output cell_slot_t                 nxt
);

    // Occupied slots are a sorted prefix, so lt is monotonic along the
    // array: a set left_lt means the insertion point lies to our left
    // and this slot shifts right by one.
    always_comb begin
        lt  = !own.valid || (in_signature < own.signature);
        nxt = own;
        if (left_lt) begin
            nxt = left;
        end else if (lt) begin
            nxt.valid     = 1'b1;
            nxt.signature = in_signature;
            nxt.index     = in_index;
        end
    end

endmodule

// File: rtl/minhash_bottomk_sorter.sv
// Bottom-k sketch builder: keeps the NUM_SLOTS smallest signatures of a
// sequence sorted ascending and drains their indices after in_last.
// Ports: clk, rst (sync, high); in_* valid/ready input stream;
// out_* valid/ready sorted drain stream; fill_count occupied slots.
// Option: define SORTER_DEDUP_EN to discard beats whose signature is
// already stored (set semantics).
module minhash_bottomk_sorter
    import minhash_pkg::*;
#(
    parameter int SIGNATURE_WIDTH = SIG_W_DEF,
    parameter int INDEX_WIDTH     = IDX_W_DEF,
    parameter int NUM_SLOTS       = SLOTS_DEF,
    parameter int SLOT_W          = $clog2(NUM_SLOTS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIGNATURE_WIDTH-1:0] in_signature,
    input  logic [INDEX_WIDTH-1:0]     in_index,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIGNATURE_WIDTH-1:0] out_signature,
    output logic [INDEX_WIDTH-1:0]     out_index,
    output logic                       out_last,
    output logic [SLOT_W-1:0]          fill_count
);

    typedef struct packed {
        logic                       valid;
        logic [SIGNATURE_WIDTH-1:0] signature;
        logic [INDEX_WIDTH-1:0]     index;
    } sorter_slot_t;

    state_t       state;
    state_t       state_nxt;
    sorter_slot_t slots    [NUM_SLOTS];
    sorter_slot_t slot_nxt [NUM_SLOTS];
    sorter_slot_t rd_slot;
    logic [NUM_SLOTS-1:0] lt;
    logic [SLOT_W-1:0]    rd_ptr;
    logic                 rd_last;
    logic                 dup;
    logic                 in_fire;
    logic                 out_fire;
    logic                 insert;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_cell
        if (i == 0) begin : g_head
            bottomk_insert_cell #(
                .SIGNATURE_WIDTH(SIGNATURE_WIDTH),
                .INDEX_WIDTH    (INDEX_WIDTH),
                .cell_slot_t    (sorter_slot_t)
            ) u_cell (
                .own         (slots[i]),
                .left        ('0),
                .left_lt     (1'b0),
                .in_signature(in_signature),
                .in_index    (in_index),
                .lt          (lt[i]),
                .nxt         (slot_nxt[i])
            );
        end else begin : g_body
            bottomk_insert_cell #(
                .SIGNATURE_WIDTH(SIGNATURE_WIDTH),
                .INDEX_WIDTH    (INDEX_WIDTH),
                .cell_slot_t    (sorter_slot_t)
            ) u_cell (
                .own         (slots[i]),
                .left        (slots[i-1]),
                .left_lt     (lt[i-1]),
                .in_signature(in_signature),
                .in_index    (in_index),
                .lt          (lt[i]),
                .nxt         (slot_nxt[i])
            );
        end
    end

`ifdef SORTER_DEDUP_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slots[i].valid &&
                slots[i].signature == in_signature) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // No lt bit set means the beat is larger than a full sketch.
    assign insert   = in_fire && (|lt) && !dup;
    assign rd_last  = (rd_ptr == fill_count - SLOT_W'(1));

    always_comb begin
        rd_slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_ptr == SLOT_W'(i)) begin
                rd_slot = slots[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // An empty DRAIN has nothing to emit; it just falls back to ACCEPT.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = (fill_count != '0);
                if (fill_count == '0 ||
                    (out_ready && rd_last)) begin
                    state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    assign out_signature = out_valid ? rd_slot.signature : '0;
    assign out_index     = out_valid ? rd_slot.index : '0;
    assign out_last      = out_valid && rd_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
            fill_count <= '0;
            rd_ptr     <= '0;
        end else begin
            if (insert) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    slots[i] <= slot_nxt[i];
                end
                if (fill_count != SLOT_W'(NUM_SLOTS)) begin
                    fill_count <= fill_count + SLOT_W'(1);
                end
            end
            if (in_fire && in_last) begin
                rd_ptr <= '0;
            end
            if (state == DRAIN) begin
                if (fill_count == '0 || (out_fire && rd_last)) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        slots[i].valid <= 1'b0;
                    end
                    fill_count <= '0;
                    rd_ptr     <= '0;
                end else if (out_fire) begin
                    rd_ptr <= rd_ptr + SLOT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_minhash_bottomk_sorter.sv
// Bench for minhash_bottomk_sorter (NUM_SLOTS=4): directed and random
// sequences against a queue-based bottom-k reference model.
module tb_minhash_bottomk_sorter;

    localparam int K  = 4;
    localparam int SW = 32;
    localparam int IW = 10;
    localparam int CW = $clog2(K + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_signature = '0;
    logic [IW-1:0] in_index = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_signature;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic [CW-1:0] fill_count;

    always #5 clk = ~clk;

    minhash_bottomk_sorter #(
        .SIGNATURE_WIDTH(SW),
        .INDEX_WIDTH    (IW),
        .NUM_SLOTS      (K)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signature (in_signature),
        .in_index     (in_index),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_signature(out_signature),
        .out_index    (out_index),
        .out_last     (out_last),
        .fill_count   (fill_count)
    );

    typedef struct {
        logic [SW-1:0] s;
        logic [IW-1:0] x;
    } ent_t;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Bottom-k rule: keep the K smallest, stable for equal values.
    function automatic void model_insert(input logic [SW-1:0] s,
                                         input logic [IW-1:0] x);
        int   pos;
        ent_t e;
`ifdef SORTER_DEDUP_EN
        foreach (q[i]) if (q[i].s == s) return;
`endif
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (s < q[i].s) begin
                pos = i;
                break;
            end
        end
        if (pos >= K) return;
        e.s = s;
        e.x = x;
        q.insert(pos, e);
        if (q.size() > K) void'(q.pop_back());
    endfunction

    task automatic push(input logic [SW-1:0] s,
                        input logic [IW-1:0] x,
                        input bit last);
        @(negedge clk);
        check("in_ready", in_ready, 1);
        in_valid     = 1'b1;
        in_signature = s;
        in_index     = x;
        in_last      = last;
        @(posedge clk);
        model_insert(s, x);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("fill", fill_count, q.size());
    endtask

    task automatic drain(input int hold, input int stop_after);
        int n   = 0;
        int cyc = 0;
        int f0  = q.size();
        bit rdy;
        while (q.size() > 0) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                check("drain_timeout", 0, 1);
                break;
            end
            check("out_valid", out_valid, 1);
            check("out_sig", out_signature, q[0].s);
            check("out_idx", out_index, q[0].x);
            check("out_last", out_last, q.size() == 1);
            check("fill_drain", fill_count, f0);
            if (n == stop_after) break;
            if (cyc <= hold) begin
                rdy = 1'b0;
                check("in_ready_drain", in_ready, 0);
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            out_ready    = rdy;
            in_valid     = (cyc <= hold);
            in_signature = 32'd1;
            in_index     = 10'h3ff;
            in_last      = (cyc <= hold);
            @(posedge clk);
            if (rdy) begin
                void'(q.pop_front());
                n++;
            end
            #1;
            out_ready = 1'b0;
            in_valid  = 1'b0;
            in_last   = 1'b0;
        end
        if (stop_after < 0) begin
            @(negedge clk);
            check("post_out_valid", out_valid, 0);
            check("post_in_ready", in_ready, 1);
            check("post_fill", fill_count, 0);
        end
    endtask

    initial begin
        int idx;
        int len;
        logic [SW-1:0] s;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sig", out_signature, 0);
        check("rst_out_idx", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_fill", fill_count, 0);
        rst = 1'b0;

        push(50, 0, 0);
        push(40, 1, 0);
        push(30, 2, 0);
        push(20, 3, 0);
        push(10, 4, 1);
        drain(0, -1);

        push(7, 0, 0);
        push(3, 1, 1);
        drain(0, -1);

        push(1, 0, 0);
        push(2, 1, 0);
        push(3, 2, 0);
        push(4, 3, 0);
        push(9, 4, 1);
        drain(0, -1);

        push(5, 0, 0);
        push(5, 1, 0);
        push(6, 2, 1);
        drain(0, -1);

        push(32'hffff_ffff, 0, 0);
        push(8, 1, 0);
        push(6, 2, 0);
        push(4, 3, 1);
        drain(5, -1);

        push(11, 0, 0);
        push(12, 1, 0);
        push(13, 2, 1);
        drain(0, 2);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b0;
        q.delete();
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_fill", fill_count, 0);
        check("abort_in_ready", in_ready, 1);
        push(100, 0, 0);
        push(99, 1, 1);
        drain(0, -1);

        idx = 0;
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(1, 10);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 5) == 0) s = 32'hffff_ffff;
                else s = SW'($urandom_range(0, 20));
                push(s, IW'(idx), b == len - 1);
                idx++;
            end
            drain(0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
